// File: rtl/exe_stage_mc_if.sv
// exe_stage_mc_if
// Bundles the ID/EX-side issue signals, the MEM/WB forwarding sources and the
// EX/MEM result signals of the execute stage into one interface.
//   master : driven by the pipeline control (ID/EX register, hazard logic)
//   slave  : the execute stage itself
// Signals:
//   in_valid, flush, exe_cmd           instruction presentation and kill
//   val1_sel, val2_sel, st_val_sel     forwarding selects (0/3 reg, 1 MEM, 2 WB)
//   valuein1, valuein2, st_value_in    register-file operands and store data
//   alu_res_mem, result_wb             forwarded values from MEM and WB
//   stall                              hold ID/EX while a multi-cycle op runs
//   out_valid, alu_result, st_value_out registered results towards MEM
interface exe_stage_mc_if #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4,
    parameter int FWD_W = 2
);
    logic             in_valid;
    logic             flush;
    logic [CMD_W-1:0] exe_cmd;
    logic [FWD_W-1:0] val1_sel;
    logic [FWD_W-1:0] val2_sel;
    logic [FWD_W-1:0] st_val_sel;
    logic [WIDTH-1:0] valuein1;
    logic [WIDTH-1:0] valuein2;
    logic [WIDTH-1:0] st_value_in;
    logic [WIDTH-1:0] alu_res_mem;
    logic [WIDTH-1:0] result_wb;
    logic             stall;
    logic             out_valid;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] st_value_out;

    modport master (
        output in_valid, flush, exe_cmd, val1_sel, val2_sel, st_val_sel,
        output valuein1, valuein2, st_value_in, alu_res_mem, result_wb,
        input  stall, out_valid, alu_result, st_value_out
    );

    modport slave (
        input  in_valid, flush, exe_cmd, val1_sel, val2_sel, st_val_sel,
        input  valuein1, valuein2, st_value_in, alu_res_mem, result_wb,
        output stall, out_valid, alu_result, st_value_out
    );
endinterface

// File: rtl/exe_stage_mc.sv
// exe_stage_mc
// Execute stage: three forwarding muxes, a single-cycle ALU and an iterative
// multiply/divide unit (one shift-add or restoring subtract-shift step per
// cycle, WIDTH steps). Results are registered here and feed the MEM stage.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset
//   bus  exe_stage_mc_if.slave (issue, forwarding, stall and result signals)
// Optional feature macro: SIGNED_MULDIV_EN adds signed MUL/DIV/REM on
// commands 12/13/14; without it those commands are unsupported (result 0).
module exe_stage_mc #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4,
    parameter int FWD_W = 2
) (
    input  logic          clk,
    input  logic          rst,
    exe_stage_mc_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_SUB  = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_AND  = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_OR   = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_NOR  = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_XOR  = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_SLL  = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_SRA  = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_SRL  = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_MULU = CMD_W'(9);
    localparam logic [CMD_W-1:0] CMD_DIVU = CMD_W'(10);
    localparam logic [CMD_W-1:0] CMD_REMU = CMD_W'(11);
`ifdef SIGNED_MULDIV_EN
    localparam logic [CMD_W-1:0] CMD_MUL  = CMD_W'(12);
    localparam logic [CMD_W-1:0] CMD_DIV  = CMD_W'(13);
    localparam logic [CMD_W-1:0] CMD_REM  = CMD_W'(14);
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    state_t           state_next;
    logic [SH_W-1:0]  count;
    logic [WIDTH-1:0] op1, op2, st_fwd, alu_comb;
    logic [WIDTH-1:0] mag1, mag2;
    logic             neg_in, accept, multi;
    // acc: product or partial remainder; opa: multiplicand or dividend/quotient;
    // opb: multiplier or divisor
    logic [WIDTH-1:0] acc, opa, opb, st_q;
    logic             mul_q, rem_q, neg_q;
    logic [WIDTH-1:0] acc_step, opa_step, opb_step, raw_res, final_res;
    logic [WIDTH:0]   rem_shift;

    function automatic logic [WIDTH-1:0] fwd_mux(input logic [FWD_W-1:0] sel,
                                                 input logic [WIDTH-1:0] reg_val,
                                                 input logic [WIDTH-1:0] mem_val,
                                                 input logic [WIDTH-1:0] wb_val);
        if (sel == FWD_W'(1))      return mem_val;
        else if (sel == FWD_W'(2)) return wb_val;
        else                       return reg_val;
    endfunction

    function automatic logic is_multi(input logic [CMD_W-1:0] c);
`ifdef SIGNED_MULDIV_EN
        return (c == CMD_MULU) || (c == CMD_DIVU) || (c == CMD_REMU) ||
               (c == CMD_MUL)  || (c == CMD_DIV)  || (c == CMD_REM);
`else
        return (c == CMD_MULU) || (c == CMD_DIVU) || (c == CMD_REMU);
`endif
    endfunction

    assign op1    = fwd_mux(bus.val1_sel,   bus.valuein1,    bus.alu_res_mem, bus.result_wb);
    assign op2    = fwd_mux(bus.val2_sel,   bus.valuein2,    bus.alu_res_mem, bus.result_wb);
    assign st_fwd = fwd_mux(bus.st_val_sel, bus.st_value_in, bus.alu_res_mem, bus.result_wb);
    assign multi  = is_multi(bus.exe_cmd);
    assign accept = (state == IDLE) && bus.in_valid && !bus.flush;

    // Single-cycle ALU; unsupported and multi-cycle codes fall to zero
    always_comb begin
        alu_comb = '0;
        case (bus.exe_cmd)
            CMD_ADD: alu_comb = op1 + op2;
            CMD_SUB: alu_comb = op1 - op2;
            CMD_AND: alu_comb = op1 & op2;
            CMD_OR:  alu_comb = op1 | op2;
            CMD_NOR: alu_comb = ~(op1 | op2);
            CMD_XOR: alu_comb = op1 ^ op2;
            CMD_SLL: alu_comb = op1 << op2[SH_W-1:0];
            CMD_SRA: alu_comb = $signed(op1) >>> op2[SH_W-1:0];
            CMD_SRL: alu_comb = op1 >> op2[SH_W-1:0];
            default: alu_comb = '0;
        endcase
    end

    // Signed ops iterate on magnitudes; neg_in records whether the final
    // result must be negated. A zero divisor leaves the all-ones quotient
    // un-negated, and the remainder takes the dividend's sign so divide by
    // zero returns the dividend.
    always_comb begin
        mag1   = op1;
        mag2   = op2;
        neg_in = 1'b0;
`ifdef SIGNED_MULDIV_EN
        if ((bus.exe_cmd == CMD_MUL) || (bus.exe_cmd == CMD_DIV) || (bus.exe_cmd == CMD_REM)) begin
            if (op1[WIDTH-1]) mag1 = -op1;
            if (op2[WIDTH-1]) mag2 = -op2;
            if (bus.exe_cmd == CMD_MUL)
                neg_in = op1[WIDTH-1] ^ op2[WIDTH-1];
            else if (bus.exe_cmd == CMD_DIV)
                neg_in = (op1[WIDTH-1] ^ op2[WIDTH-1]) && (op2 != '0);
            else
                neg_in = op1[WIDTH-1];
        end
`endif
    end

    // One iteration step of the multiply or restoring divide
    always_comb begin
        rem_shift = {acc, opa[WIDTH-1]};
        acc_step  = acc;
        opa_step  = opa;
        opb_step  = opb;
        if (mul_q) begin
            acc_step = opb[0] ? (acc + opa) : acc;
            opa_step = opa << 1;
            opb_step = opb >> 1;
        end else if (rem_shift >= {1'b0, opb}) begin
            acc_step = rem_shift[WIDTH-1:0] - opb;
            opa_step = {opa[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = rem_shift[WIDTH-1:0];
            opa_step = {opa[WIDTH-2:0], 1'b0};
        end
        raw_res   = (mul_q || rem_q) ? acc_step : opa_step;
        final_res = neg_q ? -raw_res : raw_res;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next-state logic; flush always returns to IDLE
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.in_valid && multi) state_next = BUSY;
                BUSY:    if (count == '0)           state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        bus.stall = (state == BUSY);
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count            <= '0;
            acc              <= '0;
            opa              <= '0;
            opb              <= '0;
            st_q             <= '0;
            mul_q            <= 1'b0;
            rem_q            <= 1'b0;
            neg_q            <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.alu_result   <= '0;
            bus.st_value_out <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.flush) begin
                count <= '0;
            end else if (state == IDLE) begin
                if (accept && multi) begin
                    acc   <= '0;
                    opa   <= mag1;
                    opb   <= mag2;
                    st_q  <= st_fwd;
                    count <= SH_W'(WIDTH - 1);
`ifdef SIGNED_MULDIV_EN
                    mul_q <= (bus.exe_cmd == CMD_MULU) || (bus.exe_cmd == CMD_MUL);
                    rem_q <= (bus.exe_cmd == CMD_REMU) || (bus.exe_cmd == CMD_REM);
`else
                    mul_q <= (bus.exe_cmd == CMD_MULU);
                    rem_q <= (bus.exe_cmd == CMD_REMU);
`endif
                    neg_q <= neg_in;
                end else if (accept) begin
                    bus.alu_result   <= alu_comb;
                    bus.st_value_out <= st_fwd;
                    bus.out_valid    <= 1'b1;
                end
            end else begin
                acc   <= acc_step;
                opa   <= opa_step;
                opb   <= opb_step;
                count <= count - SH_W'(1);
                if (count == '0) begin
                    bus.alu_result   <= final_res;
                    bus.st_value_out <= st_q;
                    bus.out_valid    <= 1'b1;
                end
            end
        end
    end
endmodule
